// File: rtl/wb_buffer.sv
// ---------------------------------------------------------------------------
// wb_buffer
//
// Write-back buffer between the data cache eviction port and memory. Dirty
// victim blocks are captured into a circular FIFO and drained in order as
// STORE commands. Lookups are answered from the buffered entries so that a
// reload of a recently evicted line sees the buffered data, not stale memory.
//
// Optional feature macro: WB_COALESCE_EN
//   When defined, a push whose index matches a valid non-head entry
//   overwrites that entry's data in place instead of allocating.
//
// Ports:
//   clock, reset         clock and synchronous active-high reset
//   evict_valid/idx/blk  victim block offered by the cache
//   evict_ready          buffer accepts a victim this cycle
//   mem_cmd/idx/blk      store command for the head entry (0 NONE, 2 STORE)
//   mem_ack              memory accepted the current store
//   lookup_valid/idx     combinational lookup request
//   lookup_hit/blk       youngest matching entry (zero when no hit)
//   flush                request a full drain
//   flush_done           one-cycle pulse when the drain completes
//   overflow             sticky: a victim was offered while full and dropped
// ---------------------------------------------------------------------------
module wb_buffer #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 30,
    parameter int BLK_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             evict_valid,
    input  logic [IDX_W-1:0] evict_idx,
    input  logic [BLK_W-1:0] evict_blk,
    output logic             evict_ready,
    output logic [1:0]       mem_cmd,
    output logic [IDX_W-1:0] mem_idx,
    output logic [BLK_W-1:0] mem_blk,
    input  logic             mem_ack,
    input  logic             lookup_valid,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic             lookup_hit,
    output logic [BLK_W-1:0] lookup_blk,
    input  logic             flush,
    output logic             flush_done,
    output logic             overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [1:0]       CMD_NONE  = 2'd0;
    localparam logic [1:0]       CMD_STORE = 2'd2;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0] idx_mem [DEPTH];
    logic [BLK_W-1:0] blk_mem [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;

    // slot_ptr[k] is the storage position of the k-th oldest entry;
    // slot_live[k] says whether that position currently holds valid data.
    logic [PTR_W-1:0] slot_ptr [DEPTH];
    logic [DEPTH-1:0] slot_live;

    logic             coalesce_ok;
    logic [PTR_W-1:0] co_ptr;
    logic             push, alloc, upd, pop;

    genvar g;
    for (g = 0; g < DEPTH; g++) begin : g_slot
        assign slot_ptr[g]  = head + PTR_W'(g);
        assign slot_live[g] = (CNT_W'(g) < count);
    end

`ifdef WB_COALESCE_EN
    logic co_match;

    // Search non-head entries only: the head may already be on the memory
    // bus, so rewriting it could change a store mid-handshake. Later slots
    // are younger, so the last match found wins.
    always_comb begin
        co_match = 1'b0;
        co_ptr   = head;
        for (int k = 1; k < DEPTH; k++) begin
            if (slot_live[k] && (idx_mem[slot_ptr[k]] == evict_idx)) begin
                co_match = 1'b1;
                co_ptr   = slot_ptr[k];
            end
        end
    end

    assign coalesce_ok = co_match && (state_q == RUN);
`else
    assign coalesce_ok = 1'b0;
    assign co_ptr      = head;
`endif

    // A coalescing push needs no free slot, so it is accepted even when full.
    assign evict_ready = (state_q == RUN) && ((count != FULL_CNT) || coalesce_ok);
    assign push        = evict_valid && evict_ready;
    assign alloc       = push && !coalesce_ok;
    assign upd         = push && coalesce_ok;
    assign pop         = (count != '0) && mem_ack;

    assign mem_cmd = (count != '0) ? CMD_STORE : CMD_NONE;
    assign mem_idx = (count != '0) ? idx_mem[head] : '0;
    assign mem_blk = (count != '0) ? blk_mem[head] : '0;

    // Entry storage carries no reset; validity is tracked by head/count.
    always_ff @(posedge clock) begin
        if (alloc) begin
            idx_mem[tail] <= evict_idx;
            blk_mem[tail] <= evict_blk;
        end
        if (upd) begin
            blk_mem[co_ptr] <= evict_blk;
        end
    end

    // FIFO pointers, occupancy, sticky overflow and FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            state_q  <= RUN;
        end else begin
            state_q <= state_d;
            if (alloc) tail <= tail + PTR_W'(1);
            if (pop)   head <= head + PTR_W'(1);
            if (alloc && !pop)      count <= count + CNT_W'(1);
            else if (!alloc && pop) count <= count - CNT_W'(1);
            if (evict_valid && (count == FULL_CNT) && !coalesce_ok)
                overflow <= 1'b1;
        end
    end

    // Flush FSM: DRAIN blocks new victims until the buffer empties, then
    // signals completion in the same cycle it returns to RUN.
    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        case (state_q)
            RUN: begin
                if (flush) state_d = DRAIN;
            end
            DRAIN: begin
                if (count == '0) begin
                    flush_done = 1'b1;
                    state_d    = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Lookup walks oldest to youngest so the youngest match overrides.
    // The popping head is still counted this cycle, keeping it visible.
    always_comb begin
        lookup_hit = 1'b0;
        lookup_blk = '0;
        if (lookup_valid) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (slot_live[k] && (idx_mem[slot_ptr[k]] == lookup_idx)) begin
                    lookup_hit = 1'b1;
                    lookup_blk = blk_mem[slot_ptr[k]];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_buffer.sv
// ---------------------------------------------------------------------------
// tb_wb_buffer
//
// Directed bench for wb_buffer. Expected stores are queued as victims are
// pushed; a monitor pops and compares on every acknowledged STORE.
// ---------------------------------------------------------------------------
module tb_wb_buffer;

    localparam int IDX_W = 30;
    localparam int BLK_W = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic             evict_valid;
    logic [IDX_W-1:0] evict_idx;
    logic [BLK_W-1:0] evict_blk;
    logic             evict_ready;
    logic [1:0]       mem_cmd;
    logic [IDX_W-1:0] mem_idx;
    logic [BLK_W-1:0] mem_blk;
    logic             mem_ack;
    logic             lookup_valid;
    logic [IDX_W-1:0] lookup_idx;
    logic             lookup_hit;
    logic [BLK_W-1:0] lookup_blk;
    logic             flush;
    logic             flush_done;
    logic             overflow;

    int errors = 0;
    int checks = 0;
    logic [IDX_W+BLK_W-1:0] exp_q [$];
    logic [IDX_W+BLK_W-1:0] exp_front;

    wb_buffer #(.DEPTH(4), .IDX_W(IDX_W), .BLK_W(BLK_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .evict_valid  (evict_valid),
        .evict_idx    (evict_idx),
        .evict_blk    (evict_blk),
        .evict_ready  (evict_ready),
        .mem_cmd      (mem_cmd),
        .mem_idx      (mem_idx),
        .mem_blk      (mem_blk),
        .mem_ack      (mem_ack),
        .lookup_valid (lookup_valid),
        .lookup_idx   (lookup_idx),
        .lookup_hit   (lookup_hit),
        .lookup_blk   (lookup_blk),
        .flush        (flush),
        .flush_done   (flush_done),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    // Monitor: every acknowledged STORE must match the oldest expected entry.
    always @(negedge clock) begin
        if (!reset && mem_ack && (mem_cmd == 2'd2)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL store_order: got %h/%h expected no store", mem_idx, mem_blk);
            end else begin
                exp_front = exp_q.pop_front();
                if ({mem_idx, mem_blk} !== exp_front) begin
                    errors++;
                    $display("[TB] FAIL store_order: got %h/%h expected %h/%h",
                             mem_idx, mem_blk, exp_front[IDX_W+BLK_W-1:BLK_W], exp_front[BLK_W-1:0]);
                end
            end
        end
    end

    // Hard stop in case a bounded loop is ever bypassed.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic applyStimulus(input logic ev, input logic [IDX_W-1:0] idx,
                                 input logic [BLK_W-1:0] blk, input logic ack,
                                 input logic fl);
        evict_valid = ev;
        evict_idx   = idx;
        evict_blk   = blk;
        mem_ack     = ack;
        flush       = fl;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkStore(input string name, input logic [IDX_W-1:0] idx, input logic [BLK_W-1:0] blk);
        checkOutput({name, "_cmd"}, 64'(mem_cmd), 64'd2);
        checkOutput({name, "_idx"}, 64'(mem_idx), 64'(idx));
        checkOutput({name, "_blk"}, 64'(mem_blk), 64'(blk));
    endtask

    task automatic checkReset(input string name);
        checkOutput({name, "_ready"},  64'(evict_ready), 64'd1);
        checkOutput({name, "_cmd"},    64'(mem_cmd),     64'd0);
        checkOutput({name, "_idx"},    64'(mem_idx),     64'd0);
        checkOutput({name, "_blk"},    64'(mem_blk),     64'd0);
        checkOutput({name, "_hit"},    64'(lookup_hit),  64'd0);
        checkOutput({name, "_lblk"},   64'(lookup_blk),  64'd0);
        checkOutput({name, "_fdone"},  64'(flush_done),  64'd0);
        checkOutput({name, "_ovf"},    64'(overflow),    64'd0);
    endtask

    // Push one victim that the bench expects to be accepted as a new entry.
    task automatic pushEntry(input logic [IDX_W-1:0] idx, input logic [BLK_W-1:0] blk, input logic ack);
        applyStimulus(1'b1, idx, blk, ack, 1'b0);
        settle();
        checkOutput($sformatf("ready_push_%h", idx), 64'(evict_ready), 64'd1);
        exp_q.push_back({idx, blk});
        cycle();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic drainAll(input string name, input int budget);
        int n = 0;
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        while ((exp_q.size() != 0) && (n < budget)) begin
            cycle();
            n++;
        end
        checkOutput({name, "_left"}, 64'(exp_q.size()), 64'd0);
        mem_ack = 1'b0;
        settle();
        checkOutput({name, "_empty_cmd"}, 64'(mem_cmd), 64'd0);
        cycle();
    endtask

    initial begin
        reset        = 1'b1;
        lookup_valid = 1'b0;
        lookup_idx   = '0;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        cycle();
        cycle();
        settle();
        checkReset("reset");
        reset = 1'b0;
        cycle();

        // Push then drain: STORE held for 4 cycles, ack on the 4th.
        pushEntry(30'h10, 32'hAAAA, 1'b0);
        for (int i = 0; i < 3; i++) begin
            settle();
            checkStore($sformatf("hold%0d", i), 30'h10, 32'hAAAA);
            cycle();
        end
        mem_ack = 1'b1;
        settle();
        checkStore("hold3", 30'h10, 32'hAAAA);
        cycle();
        mem_ack = 1'b0;
        settle();
        checkOutput("after_ack_cmd", 64'(mem_cmd), 64'd0);
        cycle();

        // Full: four pushes, fifth dropped with overflow.
        for (int i = 1; i <= 4; i++)
            pushEntry(30'(i), 32'(32'h100 + i), 1'b0);
        applyStimulus(1'b1, 30'h5, 32'h105, 1'b0, 1'b0);
        settle();
        checkOutput("full_ready", 64'(evict_ready), 64'd0);
        checkOutput("full_ovf_before", 64'(overflow), 64'd0);
        cycle();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        settle();
        checkOutput("full_ovf_after", 64'(overflow), 64'd1);
        checkStore("full_head", 30'h1, 32'h101);
        cycle();
        drainAll("full_drain", 10);

        // Lookup: duplicates, youngest wins, no same-cycle bypass.
        lookup_valid = 1'b1;
        lookup_idx   = 30'h20;
        applyStimulus(1'b1, 30'h20, 32'h1111, 1'b0, 1'b0);
        settle();
        checkOutput("lk_no_bypass", 64'(lookup_hit), 64'd0);
        exp_q.push_back({30'h20, 32'h1111});
        cycle();
        pushEntry(30'h20, 32'h2222, 1'b0);
        settle();
        checkOutput("lk_hit", 64'(lookup_hit), 64'd1);
        checkOutput("lk_blk", 64'(lookup_blk), 64'h2222);
        lookup_idx = 30'h21;
        settle();
        checkOutput("lk_miss_hit", 64'(lookup_hit), 64'd0);
        checkOutput("lk_miss_blk", 64'(lookup_blk), 64'd0);
        lookup_idx   = 30'h20;
        lookup_valid = 1'b0;
        settle();
        checkOutput("lk_invalid_hit", 64'(lookup_hit), 64'd0);
        lookup_valid = 1'b1;
        mem_ack      = 1'b1;
        cycle();
        settle();
        checkOutput("lk_pop_visible", 64'(lookup_blk), 64'h2222);
        cycle();
        settle();
        checkOutput("lk_gone", 64'(lookup_hit), 64'd0);
        mem_ack      = 1'b0;
        lookup_valid = 1'b0;
        checkOutput("lk_q_left", 64'(exp_q.size()), 64'd0);
        cycle();

`ifdef WB_COALESCE_EN
        // Coalesce: the second 0x40 overwrites the buffered non-head entry.
        pushEntry(30'h30, 32'h3030, 1'b0);
        pushEntry(30'h40, 32'h4040, 1'b0);
        void'(exp_q.pop_back());
        pushEntry(30'h40, 32'hBEEF, 1'b0);
        lookup_valid = 1'b1;
        lookup_idx   = 30'h40;
        settle();
        checkOutput("co_lookup", 64'(lookup_blk), 64'hBEEF);
        lookup_valid = 1'b0;
        cycle();
        drainAll("co_drain", 6);
`endif

        // Flush with 3 entries, ack every cycle, victims offered but refused.
        for (int i = 1; i <= 3; i++)
            pushEntry(30'(30'h50 + i), 32'(32'h5000 + i), 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        cycle();
        applyStimulus(1'b1, 30'h99, 32'h9999, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            settle();
            checkOutput($sformatf("fl_ready%0d", i), 64'(evict_ready), 64'd0);
            checkOutput($sformatf("fl_done%0d", i), 64'(flush_done), 64'd0);
            if (i == 2) evict_valid = 1'b0;
            cycle();
        end
        settle();
        checkOutput("fl_done_pulse", 64'(flush_done), 64'd1);
        checkOutput("fl_done_ready", 64'(evict_ready), 64'd0);
        checkOutput("fl_done_cmd", 64'(mem_cmd), 64'd0);
        cycle();
        mem_ack = 1'b0;
        settle();
        checkOutput("fl_run_done", 64'(flush_done), 64'd0);
        checkOutput("fl_run_ready", 64'(evict_ready), 64'd1);
        cycle();

        // Flush while empty: pulse arrives on the next cycle.
        flush = 1'b1;
        settle();
        checkOutput("fe_done_now", 64'(flush_done), 64'd0);
        cycle();
        flush = 1'b0;
        settle();
        checkOutput("fe_done_next", 64'(flush_done), 64'd1);
        checkOutput("fe_ready", 64'(evict_ready), 64'd0);
        cycle();
        settle();
        checkOutput("fe_back_ready", 64'(evict_ready), 64'd1);
        cycle();

        // Wrap: ten push/pop pairs keep one entry in flight.
        pushEntry(30'h60, 32'h6000, 1'b0);
        for (int i = 1; i <= 10; i++)
            pushEntry(30'(30'h60 + i), 32'(32'h6000 + i), 1'b1);
        pushEntry(30'h70, 32'h7000, 1'b0);
        settle();
        checkStore("wrap_head", 30'h6A, 32'h600A);
        checkOutput("wrap_q_left", 64'(exp_q.size()), 64'd2);

        // Reset with two entries buffered: all outputs return to reset values.
        lookup_valid = 1'b1;
        lookup_idx   = 30'h70;
        cycle();
        reset = 1'b1;
        cycle();
        exp_q.delete();
        lookup_valid = 1'b0;
        settle();
        checkReset("mid_reset");
        reset = 1'b0;
        lookup_valid = 1'b1;
        cycle();
        settle();
        checkOutput("post_reset_hit", 64'(lookup_hit), 64'd0);
        checkOutput("post_reset_cmd", 64'(mem_cmd), 64'd0);
        lookup_valid = 1'b0;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
